// File: rtl/sram_bus_arbiter.sv
// Two-master (instruction/data) arbiter onto one SRAM-like bus with a single outstanding transaction.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed data-master priority.
module sram_bus_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [3:0]  i_select,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [3:0]  d_select,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_select,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;

    // Owner codes: master index gi maps to code gi+1 (0 = instruction, 1 = data).
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic       LAST_I   = 1'b0;
    localparam logic       LAST_D   = 1'b1;

    logic [1:0] state_reg, state_next;
    logic [1:0] owner_reg, owner_next;
    logic       last_reg,  last_next;

    logic [1:0]  mst_req;
    logic [1:0]  mst_wr;
    logic [3:0]  mst_select [2];
    logic [31:0] mst_addr   [2];
    logic [31:0] mst_wdata  [2];
    logic [1:0]  mst_owned;
    logic [1:0]  mst_addr_ok;
    logic [1:0]  mst_data_ok;

    logic        addr_phase;
    logic        data_phase;
    logic        owner_req;
    logic [1:0]  grant_code;

    assign mst_req       = {d_req, i_req};
    assign mst_wr        = {d_wr, i_wr};
    assign mst_select[0] = i_select;
    assign mst_select[1] = d_select;
    assign mst_addr[0]   = i_addr;
    assign mst_addr[1]   = d_addr;
    assign mst_wdata[0]  = i_wdata;
    assign mst_wdata[1]  = d_wdata;

    assign addr_phase = (state_reg == ST_ADDR);
    assign data_phase = (state_reg == ST_DATA);

    // Handshake returns reach only the owning master; in IDLE owner is NONE so nothing leaks.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam logic [1:0] OWN_CODE = 2'(gi + 1);
            assign mst_owned[gi]   = (owner_reg == OWN_CODE);
            assign mst_addr_ok[gi] = mst_owned[gi] & addr_phase & m_addr_ok;
            assign mst_data_ok[gi] = mst_owned[gi] & m_data_ok &
                                     (data_phase | (addr_phase & m_addr_ok));
        end
    endgenerate

    assign i_addr_ok = mst_addr_ok[0];
    assign d_addr_ok = mst_addr_ok[1];
    assign i_data_ok = mst_data_ok[0];
    assign d_data_ok = mst_data_ok[1];
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;
    assign m_req     = addr_phase;
    assign owner_req = |(mst_owned & mst_req);

    always_comb begin
        m_wr     = 1'b0;
        m_select = 4'd0;
        m_addr   = 32'd0;
        m_wdata  = 32'd0;
        if (mst_owned[0]) begin
            m_wr     = mst_wr[0];
            m_select = mst_select[0];
            m_addr   = mst_addr[0];
            m_wdata  = mst_wdata[0];
        end else if (mst_owned[1]) begin
            m_wr     = mst_wr[1];
            m_select = mst_select[1];
            m_addr   = mst_addr[1];
            m_wdata  = mst_wdata[1];
        end
    end

    always_comb begin
        grant_code = OWN_NONE;
        if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_code = (last_reg == LAST_I) ? OWN_D : OWN_I;
`else
            grant_code = OWN_D;
`endif
        end else if (d_req) begin
            grant_code = OWN_D;
        end else if (i_req) begin
            grant_code = OWN_I;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_code != OWN_NONE) begin
                    owner_next = grant_code;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        last_next  = (owner_reg == OWN_D) ? LAST_D : LAST_I;
                        owner_next = OWN_NONE;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else if (!owner_req) begin
                    // Owner withdrew before the slave took the address: nothing was issued.
                    owner_next = OWN_NONE;
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (m_data_ok) begin
                    last_next  = (owner_reg == OWN_D) ? LAST_D : LAST_I;
                    owner_next = OWN_NONE;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                owner_next = OWN_NONE;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            owner_reg <= OWN_NONE;
            last_reg  <= LAST_I;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Two-master arbiter sharing one SRAM-like external bus between the instruction-fetch port and the data-memory port of the CPU. Each master side uses the req/wr/select/addr/wdata, addr_ok/data_ok/rdata handshake that `mem_signal_extend` produces. The slave side drives the single external bus. The block allows exactly one outstanding transaction and routes `addr_ok`, `data_ok` and read data back to the granted master only.

## Interface
Parameters: none. Data and address buses are `RegBus` width (32 bits).

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset. Synchronous, active-high (`RstEnable`).
- i_req, i_wr  in  1 each  instruction master request and write flag.
- i_select  in  4  instruction master byte select.
- i_addr, i_wdata  in  32 each  instruction master address and write data.
- i_addr_ok, i_data_ok  out  1 each  instruction master handshake returns.
- i_rdata  out  32  instruction master read data.
- d_req, d_wr, d_select, d_addr, d_wdata  in  1/1/4/32/32  data master request fields.
- d_addr_ok, d_data_ok  out  1 each  data master handshake returns.
- d_rdata  out  32  data master read data.
- m_req, m_wr  out  1 each  external bus request and write flag.
- m_select  out  4  external bus byte select.
- m_addr, m_wdata  out  32 each  external bus address and write data.
- m_addr_ok, m_data_ok  in  1 each  external bus handshake inputs.
- m_rdata  in  32  external bus read data.

## Operation
The block is a three-state FSM: IDLE, ADDR, DATA. It keeps an `owner` register (NONE/I/D) and a `last` register (I/D).

IDLE:
- m_req = 0.
- If `d_req` or `i_req` is high, pick a winner, latch it into `owner`, and go to ADDR.
- With no requests, stay in IDLE.

ADDR:
- m_req = 1.
- m_wr, m_select, m_addr and m_wdata are driven combinationally from the owner's live inputs. Masters must hold these stable until their addr_ok.
- The owner's addr_ok = m_addr_ok.
- m_addr_ok=1 and m_data_ok=0 → go to DATA.
- m_addr_ok=1 and m_data_ok=1 in the same cycle → deliver both to the owner, set `last` = owner, owner = NONE, go to IDLE.
- Abort: if the owner's req is 0 and m_addr_ok is 0 → return to IDLE with owner = NONE. No transaction is issued and `last` is unchanged.

DATA:
- m_req = 0. The bus fields keep following the owner's inputs.
- On m_data_ok, the owner's data_ok = 1. Then set `last` = owner, owner = NONE, go to IDLE.
- Owner req is ignored in this state.

Routing:
- i_rdata and d_rdata are both driven with m_rdata at all times.
- addr_ok and data_ok of the non-owner are always 0.
- In IDLE, all returned ok signals are 0, even if m_addr_ok or m_data_ok is asserted (spurious signals are ignored).

Reset (rst=1 at a clock edge):
- State = IDLE, owner = NONE, last = I.
- All outputs are 0: m_req, i/d_addr_ok, i/d_data_ok; m_wr/select/addr/wdata driven to 0 while owner = NONE.
- Reset in ADDR or DATA abandons the transaction silently. Any m_data_ok arriving afterwards is ignored.

## Timing
- Grant latency: 1 cycle. A request sampled in IDLE at edge N gives m_req=1 during cycle N+1.
- Minimum transaction, with a zero-wait slave answering data_ok the cycle after addr_ok: IDLE → ADDR → DATA → IDLE, so 3 cycles per transaction.
- The same-cycle addr_ok+data_ok case takes 2 cycles.
- Back-to-back requests from one master: the next grant is evaluated in the IDLE cycle following completion.
- Outputs m_* and i/d_*_ok are combinational from state, owner and the m_* inputs. There is no extra register stage.

## Configuration
Macro `ARB_ROUND_ROBIN_EN` selects the winner rule when both masters request in IDLE:
- Defined: alternate. The master not equal to `last` wins.
- Undefined: fixed priority, data master always wins.

A single requester is always granted immediately in either configuration.

## Test plan
- Instruction read alone: i_req=1, i_addr=0xBFC00000; slave gives addr_ok in the ADDR cycle, then data_ok with m_rdata=0x3C080001 one cycle later → m_addr=0xBFC00000, i_addr_ok then i_data_ok pulses, i_rdata=0x3C080001, d_*_ok stay 0, back in IDLE after 3 cycles.
- Data write: d_req=1, d_wr=1, d_select=4'b0011, d_addr=0x80001000, d_wdata=0x1234ABCD → m_wr=1, m_select=4'b0011, m_wdata=0x1234ABCD during ADDR; d_data_ok pulses once.
- Simultaneous requests, both held for two transactions:
  - Without the macro: two consecutive data grants while i_req waits.
  - With `ARB_ROUND_ROBIN_EN`: grants go D then I (last=I after reset).
- Same-cycle addr_ok+data_ok in ADDR → owner gets both pulses in one cycle, FSM goes to IDLE, next grant one cycle later.
- Abort and spurious handshakes: owner drops req in ADDR before m_addr_ok → IDLE with no ok pulses. m_data_ok pulsed while in IDLE → no i/d_data_ok.
- Reset mid-DATA: rst=1 while waiting for data_ok → all outputs 0 next cycle. A later m_data_ok is ignored and a new i_req is granted normally.
